// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: byte-loadable instruction memory, a PC-driven fetch
// FSM (IDLE/RUN/HALT) with a one-deep synchronous read stage and a small output queue.
module instr_fetch_queue #(
  parameter int          MEM_BYTES = 1024,
  parameter int          FQ_DEPTH  = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        go,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        stop,
  output logic        err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int QW = $clog2(FQ_DEPTH);
  localparam int CW = QW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          err_q, err_d;
  logic          infl_q, infl_d;
  logic [31:0]   infl_word_q, infl_pc_q;

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] ra;
  logic [31:0]   rd_word;

  logic [31:0]   q_instr [FQ_DEPTH];
  logic [31:0]   q_pc    [FQ_DEPTH];
  logic [QW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW:0]   occupancy;

  logic redir, infl_zero, pc_oob, space, issue, flush, enq, deq, ld_in_range;
  logic [32:0] pc_end;

  // Memory: written only by the loader, zeroed by reset.
  assign ld_in_range = ld_addr < 32'(MEM_BYTES);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= '0;
    end else if (ld_en && ld_in_range) begin
      mem[ld_addr[AW-1:0]] <= ld_data;
    end
  end

  // Big-endian word at PC; only consumed when PC is word-aligned and in range.
  assign ra      = pc_q[AW-1:0];
  assign rd_word = {mem[ra], mem[ra + AW'(1)], mem[ra + AW'(2)], mem[ra + AW'(3)]};

  assign redir     = redirect_valid && !ld_en;
  assign infl_zero = infl_q && (infl_word_q == 32'h0);
  assign pc_end    = {1'b0, pc_q} + 33'd3;
  assign pc_oob    = pc_end >= 33'(MEM_BYTES);
  // In-flight word counts against capacity so the queue can never overflow.
  assign occupancy = {1'b0, count_q} + (CW+1)'(infl_q);
  assign space     = occupancy < (CW+1)'(FQ_DEPTH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    infl_d  = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    if (redir) begin
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = HALT;
        err_d   = 1'b1;
      end else begin
        state_d = RUN;
        pc_d    = redirect_pc;
        err_d   = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: if (go && !ld_en) state_d = RUN;
        RUN: begin
          // A zero word ends the stream; withholding issue drops the younger fetch.
          if (infl_zero) begin
            state_d = HALT;
          end else if (!ld_en) begin
            if (pc_oob) begin
              // Let the older in-flight word land before halting.
              if (!infl_q) begin
                state_d = HALT;
                err_d   = 1'b1;
              end
            end else if (space) begin
              issue  = 1'b1;
              infl_d = 1'b1;
              pc_d   = pc_q + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      err_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_word_q <= '0;
      infl_pc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      infl_q  <= infl_d;
      if (issue) begin
        infl_word_q <= rd_word;
        infl_pc_q   <= pc_q;
      end
    end
  end

  // Output handshake: the head transfers on any cycle with out_valid && out_ready;
  // while out_valid && !out_ready the head (instr, pc) is held unchanged.
  assign enq = infl_q && !infl_zero && !flush;
  assign deq = (count_q != '0) && out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + QW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + QW'(1);
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_instr[wr_ptr_q] <= infl_word_q;
      q_pc[wr_ptr_q]    <= infl_pc_q;
    end
  end

  assign out_valid = count_q != '0;
  assign out_instr = q_instr[rd_ptr_q];
  assign out_pc    = q_pc[rd_ptr_q];
  assign stop      = (state_q == HALT) && (count_q == '0);
  assign err       = err_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed timing scenarios plus randomized runs
// checked against a stream-level model of the memory contents.
module tb_instr_fetch_queue;

  localparam int MEM_BYTES = 256;
  localparam int FQ_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        go = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, stop, err;
  logic [31:0] out_instr, out_pc;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  mem_m [MEM_BYTES];
  logic [63:0] exp_q[$];
  logic        exp_err = 1'b0;
  logic [31:0] last_pc = '0;

  instr_fetch_queue #(
    .MEM_BYTES(MEM_BYTES),
    .FQ_DEPTH (FQ_DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .go            (go),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .stop          (stop),
    .err           (err)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the output stream is the run of nonzero big-endian words
  // starting at the given PC; running off the end of memory is an error.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    int idx;
    idx = int'(a);
    return {mem_m[idx], mem_m[idx+1], mem_m[idx+2], mem_m[idx+3]};
  endfunction

  task automatic build_exp(input logic [31:0] start);
    logic [31:0] pc;
    logic [31:0] w;
    exp_q.delete();
    exp_err = 1'b0;
    pc = start;
    for (int k = 0; k <= MEM_BYTES / 4 + 2; k++) begin
      if (longint'(pc) + 3 >= longint'(MEM_BYTES)) begin
        exp_err = 1'b1;
        break;
      end
      w = model_word(pc);
      if (w == 32'h0) break;
      exp_q.push_back({pc, w});
      pc = pc + 32'd4;
    end
  endtask

  // Scoreboard: every valid head must match the oldest expected entry.
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        check_eq("head_pc", out_pc, exp_q[0][63:32]);
        check_eq("head_instr", out_instr, exp_q[0][31:0]);
        if (out_ready) begin
          last_pc = exp_q[0][63:32];
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    ld_en = 1'b0; go = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h0;
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_stop", 32'(stop), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
    tick;
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    if (a < 32'(MEM_BYTES)) mem_m[int'(a)] = d;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] w);
    load_byte(a,          w[31:24]);
    load_byte(a + 32'd1,  w[23:16]);
    load_byte(a + 32'd2,  w[15:8]);
    load_byte(a + 32'd3,  w[7:0]);
  endtask

  task automatic end_load;
    tick;
    ld_en = 1'b0;
  endtask

  // Random consumer plus optional ignored-address loads that freeze issue.
  task automatic run_until_stop(input int budget, input bit noise);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick;
      out_ready = 1'($urandom_range(0, 1));
      if (noise && $urandom_range(0, 3) == 0) begin
        ld_en = 1'b1;
        ld_addr = 32'(MEM_BYTES) + $urandom_range(0, MEM_BYTES - 1);
        ld_data = 8'($urandom);
      end else begin
        ld_en = 1'b0;
      end
      @(negedge clk);
      if (stop) done = 1'b1;
    end
    check_eq("stop_reached", 32'(done), 32'd1);
    tick;
    ld_en = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_end(input string tag);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int beats;
    bit found;
    logic [31:0] start;
    logic [31:0] word;

    do_reset;

    // Basic stream with exact first-output latency.
    load_word(32'h0, 32'h00500093);
    load_word(32'h4, 32'h00A00113);
    load_word(32'h8, 32'h0);
    end_load;
    tick; out_ready = 1'b1; go = 1'b1; build_exp(32'h0);
    tick; go = 1'b0;
    @(negedge clk); check_eq("c0_valid", 32'(out_valid), 32'd0);
    tick; @(negedge clk); check_eq("c1_valid", 32'(out_valid), 32'd0);
    tick; @(negedge clk);
    check_eq("c2_valid", 32'(out_valid), 32'd1);
    check_eq("c2_pc", out_pc, 32'h0);
    check_eq("c2_instr", out_instr, 32'h00500093);
    tick; @(negedge clk);
    check_eq("c3_pc", out_pc, 32'h4);
    check_eq("c3_instr", out_instr, 32'h00A00113);
    run_until_stop(50, 1'b0);
    check_end("basic");

    // Redirect with two entries queued.
    for (int w = 2; w < 6; w++) load_word(32'(w * 4), 32'h1000_0000 + 32'(w));
    load_word(32'h40, 32'hAAAA_0040);
    load_word(32'h44, 32'hAAAA_0044);
    end_load;
    tick; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0; build_exp(32'h0);
    tick; redirect_valid = 1'b0;
    tick;
    tick;
    tick; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk); check_eq("queued_valid", 32'(out_valid), 32'd1);
    tick; redirect_valid = 1'b0; build_exp(32'h40); out_ready = 1'b1;
    @(negedge clk); check_eq("flush_valid", 32'(out_valid), 32'd0);
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("refill_seen", 32'(found), 32'd1);
    check_eq("refill_pc", out_pc, 32'h40);
    run_until_stop(100, 1'b0);
    check_end("redirect");

    // Misaligned redirect, then recovery.
    tick; redirect_valid = 1'b1; redirect_pc = 32'h42; exp_q.delete();
    tick; redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("misalign_err", 32'(err), 32'd1);
    check_eq("misalign_stop", 32'(stop), 32'd1);
    check_eq("misalign_valid", 32'(out_valid), 32'd0);
    tick; redirect_valid = 1'b1; redirect_pc = 32'h0; build_exp(32'h0);
    tick; redirect_valid = 1'b0;
    @(negedge clk); check_eq("realign_err", 32'(err), 32'd0);
    run_until_stop(200, 1'b1);
    check_end("recover");

    // Full memory of nonzero words: backpressure, exact depth, run to the end.
    for (int w = 0; w < MEM_BYTES / 4; w++) load_word(32'(w * 4), $urandom | 32'h100);
    end_load;
    tick; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0; build_exp(32'h0);
    tick; redirect_valid = 1'b0;
    repeat (20) tick;
    beats = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      ld_en = 1'b1;
      ld_addr = 32'(MEM_BYTES + 200);
      ld_data = 8'h0;
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) beats++;
    end
    check_eq("held_entries", 32'(beats), 32'(FQ_DEPTH));
    tick; ld_en = 1'b0;
    run_until_stop(2000, 1'b1);
    check_end("fullmem");
    check_eq("last_pc", last_pc, 32'(MEM_BYTES - 4));

    // Randomized memories and start points.
    for (int it = 0; it < 5; it++) begin
      do_reset;
      for (int w = 0; w < MEM_BYTES / 4; w++) begin
        word = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1);
        load_word(32'(w * 4), word);
      end
      end_load;
      if ($urandom_range(0, 1) == 1) begin
        tick; build_exp(32'h0); go = 1'b1;
        tick; go = 1'b0;
      end else begin
        start = 32'($urandom_range(0, MEM_BYTES / 4 + 1)) * 32'd4;
        tick; build_exp(start); redirect_valid = 1'b1; redirect_pc = start;
        tick; redirect_valid = 1'b0;
      end
      run_until_stop(3000, 1'b1);
      check_end("random");
    end

    // Reset in the middle of a full queue.
    for (int w = 0; w < 8; w++) load_word(32'(w * 4), 32'hC0DE_0000 + 32'(w));
    end_load;
    tick; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0; build_exp(32'h0);
    tick; redirect_valid = 1'b0;
    repeat (10) tick;
    @(negedge clk); check_eq("prereset_valid", 32'(out_valid), 32'd1);
    do_reset;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick;
      @(negedge clk);
      check_eq("post_reset_valid", 32'(out_valid), 32'd0);
      check_eq("post_reset_stop", 32'(stop), 32'd0);
    end
    tick; go = 1'b1; build_exp(32'h0);
    tick; go = 1'b0;
    run_until_stop(200, 1'b0);
    check_end("cleared_mem");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameters, one per line (name, default, meaning):
- MEM_BYTES, 1024, byte-addressed instruction memory size (power of 2, >= 8).
- FQ_DEPTH, 4, fetch-queue entries (power of 2, >= 2).
- RESET_PC, 0, PC loaded at reset (word-aligned).
REQ-002 The block SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on its rising edge.
- rstn, in, 1, asynchronous active-low reset.
- ld_en, in, 1, memory load strobe; fetch is frozen while high.
- ld_addr, in, 32, load byte address.
- ld_data, in, 8, load byte.
- go, in, 1, start pulse from IDLE.
- redirect_valid, in, 1, PC redirect request.
- redirect_pc, in, 32, redirect target.
- out_valid, out, 1, queue head valid.
- out_ready, in, 1, consumer accepts head.
- out_instr, out, 32, head instruction.
- out_pc, out, 32, head PC.
- stop, out, 1, fetch halted and queue drained.
- err, out, 1, sticky misaligned/out-of-range fault.

Function
REQ-003 The memory SHALL be MEM_BYTES x 8 bits; it SHALL be written only by ld_en (byte at ld_addr); ld_addr >= MEM_BYTES SHALL be ignored.
REQ-004 Instruction words SHALL be big-endian: {mem[PC], mem[PC+1], mem[PC+2], mem[PC+3]}.
REQ-005 FSM states SHALL be IDLE, RUN and HALT; reset enters IDLE.
REQ-006 IDLE->RUN SHALL occur on go=1 with ld_en=0; go SHALL be ignored in RUN and HALT.
REQ-007 In RUN, one word SHALL be issued per cycle when ld_en=0 and (queue count + in-flight) < FQ_DEPTH; PC SHALL advance by 4 per issue.
REQ-008 Memory read SHALL be synchronous: a word issued in cycle t SHALL be written into the queue at the edge ending cycle t+1 and be visible on out_valid in cycle t+2 if the queue was empty.
REQ-009 A read word equal to 32'h0 SHALL NOT be enqueued; the FSM SHALL enter HALT and discard any younger in-flight word.
REQ-010 Issue with PC+3 >= MEM_BYTES SHALL NOT occur; the FSM SHALL enter HALT instead, with err=1.
REQ-011 Dequeue SHALL occur when out_valid and out_ready are both 1; simultaneous enqueue and dequeue SHALL keep the count unchanged; the queue SHALL never overflow, and empty SHALL force out_valid=0.
REQ-012 out_instr and out_pc SHALL be held stable while out_valid=1 and out_ready=0.
REQ-013 redirect_valid SHALL take priority over every other event in every state, including IDLE, except during ld_en, when it SHALL be ignored.
REQ-014 A redirect SHALL flush the queue, drop in-flight words, load PC=redirect_pc and enter RUN; out_valid SHALL be 0 in the following cycle.
REQ-015 A redirect_pc with bits[1:0] != 0 SHALL enter HALT with err=1 and an empty queue.
REQ-016 stop SHALL be 1 exactly when the state is HALT and the queue is empty; in HALT, queued entries SHALL still drain.
REQ-017 err SHALL clear only on reset or on an aligned redirect.
REQ-018 ld_en asserted mid-RUN SHALL freeze issue; an already in-flight word SHALL still complete, and issue SHALL resume on the cycle after ld_en falls.

Reset
REQ-019 On rstn=0, PC=RESET_PC, state=IDLE, queue and in-flight state cleared, and out_valid=0, stop=0, err=0 asynchronously.
REQ-020 Memory contents SHALL be cleared to zero by reset.
REQ-021 Reset asserted mid-operation SHALL abandon all fetches; no stale entry SHALL appear after rstn rises.

Verification
REQ-022 Load 0x00500093, 0x00A00113, 0x0 at 0/4/8, go, out_ready=1 -> out (pc 0, 0x00500093) in cycle 2 and (pc 4, 0x00A00113) in cycle 3; stop=1 after the drain, err=0.
REQ-023 Fill memory with nonzero words, out_ready=0 -> exactly FQ_DEPTH entries held with head pc 0 stable; raise out_ready -> pcs 0,4,8,... consecutive with no gaps or duplicates.
REQ-024 RUN with 2 queued entries, redirect_pc=0x40 -> out_valid=0 next cycle, then first output pc 0x40; no old pc reappears.
REQ-025 Redirect to 0x42 -> HALT, err=1, stop=1; later redirect to 0x0 -> err=0 and fetch resumes.
REQ-026 Nonzero words to the end of memory -> last output pc MEM_BYTES-4, then HALT with err=1.
REQ-027 Deassert rstn mid-RUN with a full queue -> out_valid=0 immediately; after release, the block stays IDLE until go.
